// File: rtl/game_controller_pkg.sv
// Shared definitions for the game controller slice.
//   state_t      : top-level game state encoding (IDLE/RUN/DEAD)
//   BCD_W        : width of one score digit
//   SCORE_DIGITS : number of BCD digits in the score
//   SPEED_MIN/MAX: obstacle speed after (re)start and its ceiling
package game_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  localparam int unsigned BCD_W        = 4;
  localparam int unsigned SCORE_DIGITS = 4;

  localparam logic [2:0] SPEED_MIN = 3'd2;
  localparam logic [2:0] SPEED_MAX = 3'd7;

endpackage

// File: rtl/game_controller_bcd_digit.sv
// One BCD digit incrementer with ripple carry.
//   d    : current digit value (0..9)
//   cin  : add one to this digit
//   q    : next digit value, wraps 9 -> 0
//   cout : carry into the next more significant digit
module bcd_digit
  import game_controller_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  input  logic             cin,
  output logic [BCD_W-1:0] q,
  output logic             cout
);

  always_comb begin
    q    = d;
    cout = 1'b0;
    if (cin) begin
      if (d == BCD_W'(9)) begin
        q    = '0;
        cout = 1'b1;
      end else begin
        q = d + BCD_W'(1);
      end
    end
  end

endmodule

// File: rtl/game_controller.sv
// Endless-runner game controller: state machine, player jump physics,
// obstacle scrolling, BCD score and speed ramp.
//   clk, rst           : clock, synchronous active-high reset
//   i_game_tick_60hz   : frame-start pulse (physics, obstacle, dead hold)
//   i_game_tick_20hz   : score pulse
//   i_collision        : player/obstacle overlap
//   i_jump             : synchronized jump button level
//   o_state            : 0=IDLE, 1=RUN, 2=DEAD
//   o_player_h         : player height above ground
//   o_obstacle_x       : obstacle left edge
//   o_score            : four BCD digits, [15:12] most significant
//   o_speed            : obstacle pixels per 60 Hz tick
module game_controller
  import game_controller_pkg::*;
#(
  parameter int JUMP_VEL     = 12,
  parameter int GRAVITY      = 1,
  parameter int OBST_START_X = 640,
  parameter int DEAD_HOLD    = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_game_tick_60hz,
  input  logic        i_game_tick_20hz,
  input  logic        i_collision,
  input  logic        i_jump,
  output logic [1:0]  o_state,
  output logic [6:0]  o_player_h,
  output logic [9:0]  o_obstacle_x,
  output logic [15:0] o_score,
  output logic [2:0]  o_speed
);

  localparam int unsigned SCORE_W = BCD_W * SCORE_DIGITS;
  localparam int unsigned HOLD_W  = $clog2(DEAD_HOLD + 2);

  localparam logic [9:0]        START_X  = 10'(OBST_START_X);
  localparam logic signed [5:0] JV       = 6'(JUMP_VEL);
  localparam logic signed [5:0] GRAV     = 6'(GRAVITY);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(DEAD_HOLD);

  state_t              state;
  logic                jump_prev;
  logic [6:0]          player_h;
  logic signed [5:0]   vel;
  logic [9:0]          obstacle_x;
  logic [SCORE_W-1:0]  score;
  logic [2:0]          speed;
  logic [HOLD_W-1:0]   hold_cnt;

  logic                jump_edge;
  logic                on_ground;
  logic signed [8:0]   h_sum;
  logic [SCORE_W-1:0]  score_inc;
  logic [SCORE_DIGITS:0] carry;

  assign jump_edge = i_jump & ~jump_prev;
  assign on_ground = (player_h == '0) && (vel == '0);

  always_comb begin
    h_sum = $signed({2'b00, player_h}) + $signed({{3{vel[5]}}, vel});
  end

  // carry[SCORE_DIGITS] is only set when every digit is 9, so it doubles as
  // the saturation flag; carry[2] marks the tens/units 99 -> 00 roll.
  assign carry[0] = 1'b1;
  for (genvar g = 0; g < SCORE_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .d    (score[g*BCD_W +: BCD_W]),
      .cin  (carry[g]),
      .q    (score_inc[g*BCD_W +: BCD_W]),
      .cout (carry[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      jump_prev  <= 1'b0;
      player_h   <= '0;
      vel        <= '0;
      obstacle_x <= START_X;
      score      <= '0;
      speed      <= SPEED_MIN;
      hold_cnt   <= '0;
    end else begin
      jump_prev <= i_jump;
      case (state)
        ST_IDLE: begin
          if (jump_edge) begin
            state      <= ST_RUN;
            player_h   <= '0;
            vel        <= '0;
            obstacle_x <= START_X;
            score      <= '0;
            speed      <= SPEED_MIN;
          end
        end
        ST_RUN: begin
          if (i_collision) begin
            state    <= ST_DEAD;
            hold_cnt <= '0;
          end else begin
            // A ground jump edge only loads velocity; integration starts
            // on the following tick even if a tick coincides.
            if (on_ground && jump_edge) begin
              vel <= JV;
            end else if (i_game_tick_60hz && !on_ground) begin
              if (h_sum <= 0) begin
                player_h <= '0;
                vel      <= '0;
              end else begin
                player_h <= h_sum[6:0];
                vel      <= vel - GRAV;
              end
            end
            if (i_game_tick_60hz) begin
              if (obstacle_x < 10'(speed)) obstacle_x <= START_X;
              else                         obstacle_x <= obstacle_x - 10'(speed);
            end
            if (i_game_tick_20hz && !carry[SCORE_DIGITS]) begin
              score <= score_inc;
              if (carry[2] && speed != SPEED_MAX) speed <= speed + 3'd1;
            end
          end
        end
        ST_DEAD: begin
          if (jump_edge && hold_cnt == HOLD_MAX) begin
            state      <= ST_RUN;
            player_h   <= '0;
            vel        <= '0;
            obstacle_x <= START_X;
            score      <= '0;
            speed      <= SPEED_MIN;
          end else if (i_game_tick_60hz && hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_state      = state;
  assign o_player_h   = player_h;
  assign o_obstacle_x = obstacle_x;
  assign o_score      = score;
  assign o_speed      = speed;

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 SHALL have parameter JUMP_VEL, default 12, initial upward velocity in pixels per 60 Hz tick.
REQ-002 SHALL have parameter GRAVITY, default 1, velocity decrement per 60 Hz tick.
REQ-003 SHALL have parameter OBST_START_X, default 640, obstacle x after spawn or wrap.
REQ-004 SHALL have parameter DEAD_HOLD, default 60, minimum 60 Hz ticks spent in DEAD.
REQ-005 SHALL have port clk, input, 1, single clock.
REQ-006 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-007 SHALL have port i_game_tick_60hz, input, 1, one-cycle frame-start pulse.
REQ-008 SHALL have port i_game_tick_20hz, input, 1, one-cycle pulse on every third frame.
REQ-009 SHALL have port i_collision, input, 1, obstacle/player pixel overlap, per pixel.
REQ-010 SHALL have port i_jump, input, 1, already-synchronized jump button, level.
REQ-011 SHALL have port o_state, output, 2, 0=IDLE, 1=RUN, 2=DEAD.
REQ-012 SHALL have port o_player_h, output, 7, player height above ground in pixels.
REQ-013 SHALL have port o_obstacle_x, output, 10, obstacle left-edge x.
REQ-014 SHALL have port o_score, output, 16, four BCD digits, [15:12] most significant.
REQ-015 SHALL have port o_speed, output, 3, obstacle pixels per 60 Hz tick.

Function
REQ-016 SHALL detect a jump edge as i_jump=1 this cycle and 0 on the previous cycle, using an internal register.
REQ-017 SHALL move IDLE->RUN on a jump edge; score=0, speed=2, obstacle_x=OBST_START_X and h=0 are loaded in the same cycle.
REQ-018 SHALL move RUN->DEAD on the clock edge following any cycle with i_collision=1; this takes priority over every other event in that cycle.
REQ-019 SHALL hold DEAD for at least DEAD_HOLD 60 Hz ticks, counted by an internal counter, then move DEAD->RUN on a jump edge with the same loads as REQ-017.
REQ-020 SHALL ignore jump edges in DEAD before the hold expires; the edge is not remembered.
REQ-021 SHALL, in RUN, on a jump edge while h=0 and vel=0, set vel=JUMP_VEL; jump edges while airborne are ignored.
REQ-022 SHALL, in RUN, on each 60 Hz tick while airborne: new h=h+vel, then vel=vel-GRAVITY; vel is signed 6-bit.
REQ-023 SHALL clamp landing: if h+vel<=0 on a tick, then h=0 and vel=0.
REQ-024 SHALL, when a jump edge and a 60 Hz tick coincide on the ground, apply the velocity load first; the tick integrates starting from the next tick.
REQ-025 SHALL, in RUN, on each 60 Hz tick: obstacle_x=obstacle_x-speed; if obstacle_x<speed, obstacle_x=OBST_START_X instead (wrap, no underflow).
REQ-026 SHALL, in RUN, increment the BCD score by 1 on each 20 Hz tick; each digit wraps 9->0 with carry; the score saturates at 9999.
REQ-027 SHALL increment speed by 1 (saturating at 7) in the cycle the tens and units digits roll 99->00.
REQ-028 SHALL freeze h, obstacle_x, score and speed in DEAD and IDLE; the final score stays visible in DEAD.
REQ-029 SHALL drive all outputs directly from registers, with no combinational path from inputs to outputs.
REQ-030 SHALL apply at most one state transition per cycle; a collision in IDLE or DEAD is ignored.

Reset
REQ-031 SHALL, on rst=1 at a clock edge: state=IDLE, h=0, vel=0, obstacle_x=OBST_START_X, score=0, speed=2, hold counter=0, jump history register=0.
REQ-032 SHALL let rst asserted mid-jump or mid-DEAD abort immediately, with the reset values visible the next cycle.

Structure
REQ-033 SHALL place the state encodings (IDLE/RUN/DEAD), the speed bounds (2, 7) and the BCD width in the shared game package.
REQ-034 SHALL implement one BCD digit with carry-in/carry-out as sub-module bcd_digit, instantiated four times.

Verification
REQ-035 SHALL cover: rst, then i_jump 0->1 -> o_state=1 the next cycle, o_score=0x0000, o_speed=2, o_obstacle_x=640.
REQ-036 SHALL cover: in RUN, a jump edge, then 60 Hz ticks -> o_player_h goes 12, 23, 33, ..., peaks at 78, returns to 0, and never goes negative.
REQ-037 SHALL cover: in RUN, 300 20 Hz ticks -> o_score=0x0300 and o_speed=5; 9999 ticks then 1 more -> o_score stays 0x9999.
REQ-038 SHALL cover: i_collision=1 for one cycle coinciding with a 20 Hz tick -> o_state=2 and the score is not incremented.
REQ-039 SHALL cover: in DEAD, a jump edge at tick 30 -> stays DEAD; a jump edge after tick 60 -> RUN with o_score=0.
REQ-040 SHALL cover: obstacle_x=3 with speed=4 on a 60 Hz tick -> o_obstacle_x=640; rst mid-jump -> o_player_h=0 the next cycle.
